// File: rtl/morse_pkg.sv
// Shared types and constants for the morse message arbiter.
package morse_pkg;

  // Arbiter FSM states: waiting for a message, forwarding it, appending the separator.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_SEP    = 2'd2
  } state_e;

  // Default message separator.
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Index reached by stepping 'off' slots forward from 'ptr' in a ring of 'n'.
  function automatic int unsigned rr_wrap(input int unsigned ptr,
                                          input int unsigned off,
                                          input int unsigned n);
    rr_wrap = (ptr + off) % n;
  endfunction

endpackage

// File: rtl/morse_rr_pick.sv
// Combinational round-robin selector: first candidate strictly after the pointer, wrapping.
module morse_rr_pick
  import morse_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         cand_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         onehot_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(NUM_REQ);

  // Scan from pointer+1 around the ring; the pointer slot itself is checked last.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if ((onehot_o == '0) && cand_i[rr_wrap(32'(ptr_i), off, NUM_REQ)]) begin
        onehot_o[rr_wrap(32'(ptr_i), off, NUM_REQ)] = 1'b1;
        idx_o = IW'(rr_wrap(32'(ptr_i), off, NUM_REQ));
      end else begin
        onehot_o = onehot_o;
      end
    end
  end

endmodule

// File: rtl/morse_msg_arbiter.sv
// Message-granular round-robin arbiter in front of the morse core's character FIFO.
// Whole messages are granted, an optional separator follows each one, and a watchdog
// aborts a granted requester that goes silent mid-message.
module morse_msg_arbiter
  import morse_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter int         TIMEOUT  = 1024,
  parameter int         SEP_EN   = 1,
  parameter logic [7:0] SEP_CHAR = ASCII_SPACE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         write_en,
  output logic [7:0]                   ascii_in,
  input  logic                         full,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         abort
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LIMIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam state_e        ST_END   = (SEP_EN != 0) ? ST_SEP : ST_IDLE;

  state_e               state_q;
  logic [IW-1:0]        grant_q;
  logic [IW-1:0]        ptr_q;
  logic [CW-1:0]        wd_q;
  logic [CW-1:0]        wd_d;

  logic [NUM_REQ-1:0]   cand_s;
  logic [NUM_REQ-1:0]   pick_onehot_s;
  logic [IW-1:0]        pick_idx_s;
  logic                 g_valid_s;
  logic                 g_en_s;
  logic                 g_last_s;
  logic [7:0]           g_data_s;
  logic                 wd_idle_s;
  logic                 wd_hit_s;
  logic                 abort_s;
  logic                 beat_s;

  assign cand_s = req_valid & req_en;

  morse_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .cand_i   (cand_s),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s)
  );

  // Decode the granted requester's lane and the abort / beat conditions.
  always_comb begin
    g_valid_s = req_valid[grant_q];
    g_en_s    = req_en[grant_q];
    g_last_s  = req_last[grant_q];
    g_data_s  = req_data[8*int'(grant_q) +: 8];
    wd_idle_s = ~g_valid_s & ~full;
    wd_hit_s  = (TIMEOUT != 0) && wd_idle_s && (wd_q == WD_LIMIT);
    abort_s   = (state_q == ST_STREAM) && (!g_en_s || wd_hit_s);
    beat_s    = (state_q == ST_STREAM) && !abort_s && g_valid_s && !full;
    // Silent cycles advance the watchdog, full holds it, accepted beats clear it.
    if (beat_s) begin
      wd_d = '0;
    end else if (wd_idle_s && (TIMEOUT != 0)) begin
      wd_d = wd_q + CW'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  // Drive the requester handshake and the FIFO write port from the current state.
  always_comb begin
    req_ready = '0;
    write_en  = 1'b0;
    ascii_in  = 8'h00;
    case (state_q)
      ST_STREAM: begin
        if (!abort_s) begin
          req_ready[grant_q] = ~full;
        end else begin
          req_ready = '0;
        end
        write_en = beat_s;
        ascii_in = g_data_s;
      end
      ST_SEP: begin
        write_en = ~full;
        ascii_in = SEP_CHAR;
      end
      default: begin
        write_en = 1'b0;
      end
    endcase
  end

  assign grant_valid = (state_q != ST_IDLE);
  assign grant_id    = grant_q;
  assign abort       = abort_s;

  // Arbitration FSM with grant, round-robin pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      wd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_q <= '0;
          if (pick_onehot_s != '0) begin
            grant_q <= pick_idx_s;
            ptr_q   <= pick_idx_s;
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (abort_s) begin
            wd_q    <= '0;
            state_q <= ST_END;
          end else begin
            wd_q <= wd_d;
            if (beat_s && g_last_s) begin
              state_q <= ST_END;
            end
          end
        end
        ST_SEP: begin
          if (!full) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_msg_arbiter.sv
// Directed, table-driven bench for morse_msg_arbiter (4 requesters, 8-cycle watchdog).
module tb_morse_msg_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        write_en;
  logic [7:0]  ascii_in;
  logic        full;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        abort;

  morse_msg_arbiter #(
    .NUM_REQ (4),
    .TIMEOUT (8),
    .SEP_EN  (1),
    .SEP_CHAR(8'h20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_en     (req_en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .write_en   (write_en),
    .ascii_in   (ascii_in),
    .full       (full),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {req_ready[3:0], write_en, ascii_in[7:0], grant_valid, grant_id[1:0], abort}
  typedef struct {
    logic        r;
    logic [3:0]  en;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        f;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [3:0] en, input logic [3:0] v,
                     input logic [31:0] d, input logic [3:0] l, input logic f,
                     input logic [3:0] rdy, input logic we, input logic [7:0] ai,
                     input logic gv, input logic [1:0] gid, input logic ab);
    vec_t t;
    t.r = r; t.en = en; t.v = v; t.d = d; t.l = l; t.f = f;
    t.exp = {rdy, we, ai, gv, gid, ab};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic [3:0] en, input logic [3:0] v,
                       input logic [31:0] d, input logic [3:0] l, input logic f);
    rst = r; req_en = en; req_valid = v; req_data = d; req_last = l; full = f;
  endtask

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {req_ready, write_en, ascii_in, grant_valid, grant_id, abort};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b we=%b ascii=%h gv=%b gid=%0d ab=%b, expected rdy=%b we=%b ascii=%h gv=%b gid=%0d ab=%b",
               name, act[16:13], act[12], act[11:4], act[3], act[2:1], act[0],
               exp[16:13], exp[12], exp[11:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  // Apply inputs just after the edge, check mid-cycle, then advance one clock.
  task automatic step(input string name, input logic r, input logic [3:0] en,
                      input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                      input logic f, input logic [16:0] exp);
    drive(r, en, v, d, l, f);
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'h0, 4'h0, 32'h0, 4'h0, 1'b0);
    @(posedge clk);
    #1;

    // 1: req0 sends "SOS", then the separator
    add(1'b1, 4'h0, 4'h0, 32'h0,  4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h1, 32'h53, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h1, 32'h53, 4'h0, 1'b0, 4'h1, 1'b1, 8'h53, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h1, 32'h4F, 4'h0, 1'b0, 4'h1, 1'b1, 8'h4F, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h1, 32'h53, 4'h1, 1'b0, 4'h1, 1'b1, 8'h53, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h0, 32'h0,  4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h0, 32'h0,  4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    // 2: req0 and req2 contend from reset; whole messages, then req0 again (round robin)
    add(1'b1, 4'h5, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h5, 32'h00580041, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h5, 32'h00580041, 4'h0, 1'b0, 4'h1, 1'b1, 8'h41, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h5, 32'h00580042, 4'h1, 1'b0, 4'h1, 1'b1, 8'h42, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h4, 32'h00580000, 4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h4, 32'h00580000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h5, 32'h00580043, 4'h0, 1'b0, 4'h4, 1'b1, 8'h58, 1'b1, 2'd2, 1'b0);
    add(1'b0, 4'h5, 4'h5, 32'h00590043, 4'h4, 1'b0, 4'h4, 1'b1, 8'h59, 1'b1, 2'd2, 1'b0);
    add(1'b0, 4'h5, 4'h1, 32'h00000043, 4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd2, 1'b0);
    add(1'b0, 4'h5, 4'h1, 32'h00000043, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
    add(1'b0, 4'h5, 4'h1, 32'h00000043, 4'h1, 1'b0, 4'h1, 1'b1, 8'h43, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h5, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    // 3: full held 5 cycles mid-message, and during the separator
    add(1'b0, 4'h1, 4'h1, 32'h48, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h1, 32'h48, 4'h0, 1'b0, 4'h1, 1'b1, 8'h48, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 4'h1, 4'h1, 32'h49, 4'h0, 1'b1, 4'h0, 1'b0, 8'h49, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h1, 32'h49, 4'h1, 1'b0, 4'h1, 1'b1, 8'h49, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h0, 32'h0,  4'h0, 1'b1, 4'h0, 1'b0, 8'h20, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h0, 32'h0,  4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h1, 4'h0, 32'h0,  4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    // 5: req_en[3] cleared mid-message -> abort; req3 then ignored, req1 served
    add(1'b0, 4'h8, 4'h8, 32'h4D000000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h8, 4'h8, 32'h4D000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'h4D, 1'b1, 2'd3, 1'b0);
    add(1'b0, 4'h2, 4'hA, 32'h4E004B00, 4'h0, 1'b0, 4'h0, 1'b0, 8'h4E, 1'b1, 2'd3, 1'b1);
    add(1'b0, 4'h2, 4'hA, 32'h4E004B00, 4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd3, 1'b0);
    add(1'b0, 4'h2, 4'hA, 32'h4E004B00, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0);
    add(1'b0, 4'h2, 4'hA, 32'h4E004B00, 4'h2, 1'b0, 4'h2, 1'b1, 8'h4B, 1'b1, 2'd1, 1'b0);
    add(1'b0, 4'h2, 4'h8, 32'h4E000000, 4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd1, 1'b0);
    add(1'b0, 4'h2, 4'h8, 32'h4E000000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0);
    add(1'b0, 4'h2, 4'h8, 32'h4E000000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0);
    // 6: rst during STREAM, then req0 beats simultaneous req1
    add(1'b0, 4'h1, 4'h1, 32'h50,   4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0);
    add(1'b0, 4'h1, 4'h1, 32'h50,   4'h0, 1'b0, 4'h1, 1'b1, 8'h50, 1'b1, 2'd0, 1'b0);
    add(1'b1, 4'h1, 4'h1, 32'h50,   4'h0, 1'b0, 4'h1, 1'b1, 8'h50, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h3, 4'h3, 32'h5251, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h3, 4'h3, 32'h5251, 4'h1, 1'b0, 4'h1, 1'b1, 8'h51, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h3, 4'h2, 32'h5200, 4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd0, 1'b0);
    add(1'b0, 4'h3, 4'h2, 32'h5200, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    add(1'b0, 4'h3, 4'h2, 32'h5200, 4'h2, 1'b0, 4'h2, 1'b1, 8'h52, 1'b1, 2'd1, 1'b0);
    add(1'b0, 4'h3, 4'h0, 32'h0,    4'h0, 1'b0, 4'h0, 1'b1, 8'h20, 1'b1, 2'd1, 1'b0);
    add(1'b0, 4'h3, 4'h0, 32'h0,    4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].en, vecs[i].v, vecs[i].d,
           vecs[i].l, vecs[i].f, vecs[i].exp);

    // 4: watchdog -- req1 sends one char then goes silent; full cycles do not count
    step("wd_idle",  1'b0, 4'h2, 4'h2, 32'h3100, 4'h0, 1'b0, {4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0});
    step("wd_beat",  1'b0, 4'h2, 4'h2, 32'h3100, 4'h0, 1'b0, {4'h2, 1'b1, 8'h31, 1'b1, 2'd1, 1'b0});
    for (int k = 1; k <= 3; k++)
      step($sformatf("wd_silent%0d", k), 1'b0, 4'h2, 4'h0, 32'h0, 4'h0, 1'b0,
           {4'h2, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0});
    for (int k = 0; k < 4; k++)
      step($sformatf("wd_full%0d", k), 1'b0, 4'h2, 4'h0, 32'h0, 4'h0, 1'b1,
           {4'h0, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0});
    for (int k = 4; k <= 7; k++)
      step($sformatf("wd_silent%0d", k), 1'b0, 4'h2, 4'h0, 32'h0, 4'h0, 1'b0,
           {4'h2, 1'b0, 8'h00, 1'b1, 2'd1, 1'b0});
    step("wd_abort", 1'b0, 4'h2, 4'h0, 32'h0, 4'h0, 1'b0, {4'h0, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1});
    step("wd_sep",   1'b0, 4'h2, 4'h0, 32'h0, 4'h0, 1'b0, {4'h0, 1'b1, 8'h20, 1'b1, 2'd1, 1'b0});
    step("wd_done",  1'b0, 4'h2, 4'h0, 32'h0, 4'h0, 1'b0, {4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
